// File: rtl/bank_issue_queue.sv
// bank_issue_queue: in-order request FIFO and scheduler in front of the 8-bank data memory.
// Latency: a request accepted at edge N starts its bank at edge N+1 when the queue is empty
//          and the bank is idle; the tagged response is registered one cycle after bank_done.
// Backpressure: req_ready drops when the FIFO holds DEPTH entries. A blocked head stalls the
//               whole queue because issue is strictly in order. Responses cannot be backpressured.
//
// Ports:
//   clk, reset           clock, asynchronous active-high reset
//   req_*                request in (valid/ready); addr[2:0] = bank, addr[8:3] = bank row
//   bank_start/addr/rw/wdata  registered issue to the banks (start is a one-cycle one-hot pulse)
//   bank_ready/done/rdata     per-bank status and read data (bank b at [32b+31:32b])
//   resp_*               one-cycle tagged response pulse
//   err                  sticky, set when more than one bank_done bit is seen in one cycle
//   stall_cnt            present only when PERF_CNT_EN is defined: saturating count of
//                        cycles in which the head is valid but not issued
module bank_issue_queue #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [8:0]         req_addr,
    input  logic               req_rw,
    input  logic [31:0]        req_wdata,
    input  logic [TAG_W-1:0]   req_tag,
    output logic [7:0]         bank_start,
    output logic [5:0]         bank_addr,
    output logic               bank_rw,
    output logic [31:0]        bank_wdata,
    input  logic [7:0]         bank_ready,
    input  logic [7:0]         bank_done,
    input  logic [255:0]       bank_rdata,
    output logic               resp_valid,
    output logic [TAG_W-1:0]   resp_tag,
    output logic               resp_rw,
    output logic [31:0]        resp_rdata,
    output logic               err
`ifdef PERF_CNT_EN
    ,
    output logic [15:0]        stall_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [8:0]       addr;
        logic             rw;
        logic [31:0]      wdata;
        logic [TAG_W-1:0] tag;
    } req_t;

    req_t             fifo [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;

    logic [7:0]       busy;
    logic [7:0]       busy_nxt;
    logic [TAG_W-1:0] tag_reg [8];
    logic [7:0]       rw_reg;

    req_t             head;
    logic             head_vld;
    logic [2:0]       head_bank;
    logic             issue;
    logic             push;
    logic [7:0]       done_hit;
    logic             resp_hit;
    logic [2:0]       resp_idx;
    logic             multi_done;

    // Ready depends on occupancy only, so a full queue rejects a push even in a pop cycle.
    assign req_ready  = (count < CW'(DEPTH));
    assign push       = req_valid & req_ready;

    assign head       = fifo[rd_ptr];
    assign head_vld   = (count != '0);
    assign head_bank  = head.addr[2:0];
    // A busy bank finishing this cycle may take the next element on the same edge.
    assign issue      = head_vld & bank_ready[head_bank] &
                        (~busy[head_bank] | bank_done[head_bank]);

    // Only completions of tracked elements produce responses; stray pulses are dropped.
    assign done_hit   = bank_done & busy;
    assign multi_done = ($countones(bank_done) > 1);

    // Lowest-index completion wins the single response slot.
    always_comb begin
        resp_hit = 1'b0;
        resp_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (done_hit[i]) begin
                resp_hit = 1'b1;
                resp_idx = 3'(i);
            end
        end
    end

    // Completion clears busy, a same-edge reissue sets it again.
    always_comb begin
        busy_nxt = busy & ~bank_done;
        if (issue) begin
            busy_nxt[head_bank] = 1'b1;
        end
    end

    // Storage needs no reset: entries are only read while count says they are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo[wr_ptr] <= '{addr: req_addr, rw: req_rw, wdata: req_wdata, tag: req_tag};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (issue) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, issue})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy       <= '0;
            rw_reg     <= '0;
            for (int i = 0; i < 8; i++) begin
                tag_reg[i] <= '0;
            end
            bank_start <= '0;
            bank_addr  <= '0;
            bank_rw    <= 1'b0;
            bank_wdata <= '0;
        end else begin
            busy       <= busy_nxt;
            bank_start <= '0;
            if (issue) begin
                bank_start         <= 8'd1 << head_bank;
                bank_addr          <= head.addr[8:3];
                bank_rw            <= head.rw;
                bank_wdata         <= head.wdata;
                tag_reg[head_bank] <= head.tag;
                rw_reg[head_bank]  <= head.rw;
            end
        end
    end

    // Response fields hold their last value between pulses; only resp_valid is pulsed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            resp_valid <= 1'b0;
            resp_tag   <= '0;
            resp_rw    <= 1'b0;
            resp_rdata <= '0;
            err        <= 1'b0;
        end else begin
            resp_valid <= resp_hit;
            if (resp_hit) begin
                resp_tag   <= tag_reg[resp_idx];
                resp_rw    <= rw_reg[resp_idx];
                resp_rdata <= rw_reg[resp_idx] ? 32'd0 : bank_rdata[{resp_idx, 5'b0} +: 32];
            end
            if (multi_done) begin
                err <= 1'b1;
            end
        end
    end

`ifdef PERF_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (head_vld && !issue && stall_cnt != 16'hFFFF) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_bank_issue_queue.sv
// tb_bank_issue_queue: directed stimulus against a queue-based model of the issue queue.
// Latency: model state advances at each posedge; DUT outputs compared every negedge.
// Backpressure: the bench drives bank_ready/bank_done directly to create stalls and completions.
module tb_bank_issue_queue;

    localparam int DEPTH = 4;
    localparam int TAG_W = 6;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [8:0]       req_addr = '0;
    logic             req_rw = 1'b0;
    logic [31:0]      req_wdata = '0;
    logic [TAG_W-1:0] req_tag = '0;
    logic [7:0]       bank_start;
    logic [5:0]       bank_addr;
    logic             bank_rw;
    logic [31:0]      bank_wdata;
    logic [7:0]       bank_ready = 8'hFF;
    logic [7:0]       bank_done = 8'h00;
    logic [255:0]     bank_rdata = '0;
    logic             resp_valid;
    logic [TAG_W-1:0] resp_tag;
    logic             resp_rw;
    logic [31:0]      resp_rdata;
    logic             err;
`ifdef PERF_CNT_EN
    logic [15:0]      stall_cnt;
`endif

    bank_issue_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_rw     (req_rw),
        .req_wdata  (req_wdata),
        .req_tag    (req_tag),
        .bank_start (bank_start),
        .bank_addr  (bank_addr),
        .bank_rw    (bank_rw),
        .bank_wdata (bank_wdata),
        .bank_ready (bank_ready),
        .bank_done  (bank_done),
        .bank_rdata (bank_rdata),
        .resp_valid (resp_valid),
        .resp_tag   (resp_tag),
        .resp_rw    (resp_rw),
        .resp_rdata (resp_rdata),
`ifdef PERF_CNT_EN
        .stall_cnt  (stall_cnt),
`endif
        .err        (err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    typedef struct packed {
        logic [8:0]       addr;
        logic             rw;
        logic [31:0]      wdata;
        logic [TAG_W-1:0] tag;
    } mreq_t;

    // Model: a plain queue of pending elements plus per-bank "in flight" records.
    mreq_t            mq[$];
    bit               m_busy [8];
    logic [TAG_W-1:0] m_tag [8];
    logic             m_rw [8];
    logic [7:0]       exp_start;
    logic [5:0]       exp_addr;
    logic             exp_rw;
    logic [31:0]      exp_wdata;
    logic             exp_rv;
    logic [TAG_W-1:0] exp_rtag;
    logic             exp_rrw;
    logic [31:0]      exp_rdata;
    logic             exp_err;
    logic [15:0]      exp_stall;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        for (int i = 0; i < 8; i++) begin
            m_busy[i] = 0;
            m_tag[i]  = '0;
            m_rw[i]   = 1'b0;
        end
        exp_start = '0; exp_addr = '0; exp_rw = 1'b0; exp_wdata = '0;
        exp_rv = 1'b0; exp_rtag = '0; exp_rrw = 1'b0; exp_rdata = '0;
        exp_err = 1'b0; exp_stall = '0;
    endtask

    // One clock edge of the specified behaviour, using the inputs held across that edge.
    task automatic model_step();
        bit acc;
        bit iss;
        int b;
        int j;
        int nd;
        acc = req_valid && (mq.size() < DEPTH);
        exp_rv = 1'b0;
        j = -1;
        nd = 0;
        for (int i = 0; i < 8; i++) begin
            if (bank_done[i]) nd++;
            if (j < 0 && bank_done[i] && m_busy[i]) j = i;
        end
        if (j >= 0) begin
            exp_rv    = 1'b1;
            exp_rtag  = m_tag[j];
            exp_rrw   = m_rw[j];
            exp_rdata = m_rw[j] ? 32'd0 : bank_rdata[32*j +: 32];
        end
        if (nd > 1) exp_err = 1'b1;
        iss = 0;
        b = 0;
        if (mq.size() > 0) begin
            b = int'(mq[0].addr[2:0]);
            iss = bank_ready[b] && (!m_busy[b] || bank_done[b]);
        end
        if (mq.size() > 0 && !iss && exp_stall != 16'hFFFF) exp_stall = exp_stall + 16'd1;
        for (int i = 0; i < 8; i++) begin
            if (bank_done[i]) m_busy[i] = 0;
        end
        exp_start = 8'h00;
        if (iss) begin
            exp_start = 8'd1 << b;
            exp_addr  = mq[0].addr[8:3];
            exp_rw    = mq[0].rw;
            exp_wdata = mq[0].wdata;
            m_busy[b] = 1;
            m_tag[b]  = mq[0].tag;
            m_rw[b]   = mq[0].rw;
            void'(mq.pop_front());
        end
        if (acc) mq.push_back('{addr: req_addr, rw: req_rw, wdata: req_wdata, tag: req_tag});
    endtask

    task automatic tick();
        @(posedge clk);
        if (!reset) model_step();
        #1;
    endtask

    task automatic push(input logic [8:0] a, input logic rw, input logic [31:0] d,
                        input logic [TAG_W-1:0] t);
        req_valid = 1'b1; req_addr = a; req_rw = rw; req_wdata = d; req_tag = t;
        tick();
        req_valid = 1'b0;
    endtask

    // Every-cycle comparison against the model while out of reset.
    always @(negedge clk) begin
        if (!reset) begin
            chk("bank_start", 64'(bank_start), 64'(exp_start));
            chk("bank_addr",  64'(bank_addr),  64'(exp_addr));
            chk("bank_rw",    64'(bank_rw),    64'(exp_rw));
            chk("bank_wdata", 64'(bank_wdata), 64'(exp_wdata));
            chk("resp_valid", 64'(resp_valid), 64'(exp_rv));
            chk("err",        64'(err),        64'(exp_err));
            chk("req_ready",  64'(req_ready),  64'(mq.size() < DEPTH));
            if (exp_rv) begin
                chk("resp_tag",   64'(resp_tag),   64'(exp_rtag));
                chk("resp_rw",    64'(resp_rw),    64'(exp_rrw));
                chk("resp_rdata", 64'(resp_rdata), 64'(exp_rdata));
            end
`ifdef PERF_CNT_EN
            chk("stall_cnt", 64'(stall_cnt), 64'(exp_stall));
`endif
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        model_reset();
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Reset and idle
        tick();
        chk("rst_start", 64'(bank_start), 64'h0);
        chk("rst_resp",  64'(resp_valid), 64'h0);
        chk("rst_ready", 64'(req_ready),  64'h1);
        chk("rst_err",   64'(err),        64'h0);
        chk("rst_tag",   64'(resp_tag),   64'h0);
        chk("rst_addr",  64'(bank_addr),  64'h0);

        // Write then read of address 10 (bank 2, row 1)
        push(9'd10, 1'b1, 32'hA5, 6'd3);
        push(9'd10, 1'b0, 32'h0, 6'd4);
        chk("wr_start", 64'(bank_start), 64'h04);
        chk("wr_addr",  64'(bank_addr),  64'h1);
        chk("wr_data",  64'(bank_wdata), 64'hA5);
        tick();
        chk("rd_blocked", 64'(bank_start), 64'h0);
        tick();
        bank_done = 8'h04;
        tick();
        bank_done = 8'h00;
        chk("wr_resp_v",   64'(resp_valid), 64'h1);
        chk("wr_resp_tag", 64'(resp_tag),   64'd3);
        chk("wr_resp_rw",  64'(resp_rw),    64'h1);
        chk("wr_resp_dat", 64'(resp_rdata), 64'h0);
        chk("rd_start",    64'(bank_start), 64'h04);
        chk("rd_rw",       64'(bank_rw),    64'h0);
        tick();
        bank_rdata[95:64] = 32'hA5;
        bank_done = 8'h04;
        tick();
        bank_done = 8'h00;
        chk("rd_resp_tag", 64'(resp_tag),   64'd4);
        chk("rd_resp_dat", 64'(resp_rdata), 64'hA5);
        tick();

        // Reads to banks 0..7 back to back
        for (int k = 0; k < 8; k++) begin
            bank_rdata[32*k +: 32] = 32'h100 + 32'(k);
            push(9'(k), 1'b0, 32'h0, 6'(k));
            if (k > 0) chk("walk_start", 64'(bank_start), 64'd1 << (k - 1));
        end
        tick();
        chk("walk_start7", 64'(bank_start), 64'h80);
        for (int k = 0; k < 8; k++) begin
            bank_done = 8'd1 << k;
            tick();
            chk("walk_tag",  64'(resp_tag),   64'(k));
            chk("walk_data", 64'(resp_rdata), 64'h100 + 64'(k));
        end
        bank_done = 8'h00;
        tick();
        chk("walk_err", 64'(err), 64'h0);

        // Fill the queue behind a busy bank 0
        push(9'd0, 1'b0, 32'h0, 6'd10);
        for (int k = 0; k < 5; k++) begin
            req_valid = 1'b1; req_addr = 9'(8 * (k + 1)); req_tag = 6'(11 + k);
            tick();
            chk("fill_ready", 64'(req_ready), (k < 3) ? 64'h1 : 64'h0);
        end
        repeat (2) tick();
        chk("full_hold", 64'(req_ready), 64'h0);
        bank_done = 8'h01;
        tick();
        bank_done = 8'h00;
        chk("pop_ready", 64'(req_ready), 64'h1);
        chk("pop_tag",   64'(resp_tag),  64'd10);
        tick();
        req_valid = 1'b0;
        chk("refill_ready", 64'(req_ready), 64'h0);
        for (int k = 0; k < 5; k++) begin
            bank_done = 8'h01;
            tick();
            bank_done = 8'h00;
            tick();
        end

        // Two completions in one cycle
        push(9'd0, 1'b0, 32'h0, 6'd20);
        push(9'd1, 1'b0, 32'h0, 6'd21);
        tick();
        bank_rdata[31:0] = 32'hCAFE0000;
        bank_done = 8'h03;
        tick();
        bank_done = 8'h00;
        chk("dbl_resp", 64'(resp_valid), 64'h1);
        chk("dbl_tag",  64'(resp_tag),   64'd20);
        chk("dbl_data", 64'(resp_rdata), 64'hCAFE0000);
        chk("dbl_err",  64'(err),        64'h1);
        push(9'd9, 1'b0, 32'h0, 6'd22);
        tick();
        chk("dbl_clear", 64'(bank_start), 64'h02);
        chk("err_stick", 64'(err),        64'h1);

        // Reset in the middle of a burst
        push(9'd3, 1'b0, 32'h0, 6'd30);
        push(9'd4, 1'b0, 32'h0, 6'd31);
        bank_done = 8'h08;
        push(9'd5, 1'b0, 32'h0, 6'd32);
        bank_done = 8'h00;
        chk("pre_rst_resp",  64'(resp_valid), 64'h1);
        chk("pre_rst_start", 64'(bank_start), 64'h10);
        reset = 1'b1;
        model_reset();
        #1;
        chk("mid_rst_start", 64'(bank_start), 64'h0);
        chk("mid_rst_resp",  64'(resp_valid), 64'h0);
        chk("mid_rst_ready", 64'(req_ready),  64'h1);
        chk("mid_rst_err",   64'(err),        64'h0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        bank_done = 8'h10;
        tick();
        bank_done = 8'h00;
        chk("late_done", 64'(resp_valid), 64'h0);
        tick();

        // Head held by bank_ready[2] low for five cycles
        bank_ready = 8'hFB;
        push(9'd18, 1'b0, 32'h0, 6'd40);
        repeat (5) tick();
`ifdef PERF_CNT_EN
        chk("stall_cnt5", 64'(stall_cnt), 64'd5);
`endif
        chk("stall_start", 64'(bank_start), 64'h0);
        bank_ready = 8'hFF;
        seen = 0;
        for (int c = 0; c < 4 && !seen; c++) begin
            tick();
            if (bank_start[2]) seen = 1;
        end
        chk("stall_release", 64'(seen), 64'h1);
        bank_done = 8'h04;
        tick();
        bank_done = 8'h00;
        chk("stall_tag", 64'(resp_tag), 64'd40);
        repeat (2) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
